// File: rtl/fifo_sync_flags_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_flags_if
// Description : Request/response bundle between a FIFO and its user.
//               master = producer/consumer side, slave = FIFO side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_sync_flags_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/fifo_sync_flags.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_flags
// Description : Single-clock FIFO with registered read + valid strobe,
//               occupancy count, almost-full/almost-empty thresholds,
//               sticky overflow/underflow and synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_flags #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 4,
  parameter int ALMOST_FULL_TH  = 14,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  fifo_sync_flags_if.slave bus
);

  localparam int                  c_DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_DEPTH_CNT = (ADDR_WIDTH + 1)'(c_DEPTH);
  localparam logic [ADDR_WIDTH:0] c_AF_TH     = (ADDR_WIDTH + 1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0] c_AE_TH     = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_TH);
  localparam logic [ADDR_WIDTH:0] c_ONE       = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [ADDR_WIDTH:0]   r_wptr;
  logic [ADDR_WIDTH:0]   r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_rd_acc;
  logic                  w_wr_acc;

  // Status decodes come only from registered count, never from requests.
  assign w_full   = (r_count == c_DEPTH_CNT);
  assign w_empty  = (r_count == '0);

  // A read when full frees a slot, so a simultaneous write is also taken.
  // Flush drops both requests in its cycle.
  assign w_rd_acc = bus.rd_en & ~w_empty & ~bus.flush;
  assign w_wr_acc = bus.wr_en & (~w_full | w_rd_acc) & ~bus.flush;

  // Storage array: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr[ADDR_WIDTH-1:0]] <= bus.wr_data;
    end
  end

  // Pointers and occupancy; the extra pointer bit just wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + c_ONE;
      if (w_rd_acc) r_rptr <= r_rptr + c_ONE;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + c_ONE;
        2'b01:   r_count <= r_count - c_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered read port: data holds between reads, valid pulses one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_rd_data <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
    end
  end

  // Sticky error flags, cleared only by flush or reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.wr_en & w_full & ~w_rd_acc) r_overflow  <= 1'b1;
      if (bus.rd_en & w_empty)            r_underflow <= 1'b1;
    end
  end

  assign bus.rd_data      = r_rd_data;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.count        = r_count;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= c_AF_TH);
  assign bus.almost_empty = (r_count <= c_AE_TH);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_flags.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync_flags
// Description : Self-checking bench for fifo_sync_flags: vector table,
//               directed corner sequences and random traffic against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_flags;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF_TH = 14;
  localparam int AE_TH = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  fifo_sync_flags_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fifo_sync_flags #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .ALMOST_FULL_TH (AF_TH),
    .ALMOST_EMPTY_TH(AE_TH)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: contents as a queue plus observable registers.
  logic [7:0] q[$];
  logic       m_ov    = 1'b0;
  logic       m_un    = 1'b0;
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;

  typedef struct {
    logic       f;
    logic       w;
    logic [7:0] wd;
    logic       r;
    int         cnt;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
    logic       ov;
    logic       un;
    logic       vld;
    logic [7:0] data;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"},        32'(bus.count),        32'(n));
    chk({tag, ".full"},         32'(bus.full),         32'(n == DEPTH));
    chk({tag, ".empty"},        32'(bus.empty),        32'(n == 0));
    chk({tag, ".almost_full"},  32'(bus.almost_full),  32'(n >= AF_TH));
    chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(n <= AE_TH));
    chk({tag, ".overflow"},     32'(bus.overflow),     32'(m_ov));
    chk({tag, ".underflow"},    32'(bus.underflow),    32'(m_un));
    chk({tag, ".rd_valid"},     32'(bus.rd_valid),     32'(m_valid));
    chk({tag, ".rd_data"},      32'(bus.rd_data),      32'(m_data));
  endtask

  task automatic model_reset();
    q.delete();
    m_ov    = 1'b0;
    m_un    = 1'b0;
    m_valid = 1'b0;
    m_data  = 8'h00;
  endtask

  // One clock of traffic: drive, advance the model at the edge, then sample.
  task automatic step(input logic f, input logic w, input logic [7:0] wd,
                      input logic r, input bit chk_en, input string tag);
    bit was_full, was_empty, rd_ok, wr_ok;
    bus.flush   = f;
    bus.wr_en   = w;
    bus.wr_data = wd;
    bus.rd_en   = r;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (f) begin
      q.delete();
      m_ov    = 1'b0;
      m_un    = 1'b0;
      m_valid = 1'b0;
    end else begin
      rd_ok = r && !was_empty;
      wr_ok = w && (!was_full || rd_ok);
      if (r && was_empty) m_un = 1'b1;
      if (w && !wr_ok)    m_ov = 1'b1;
      m_valid = rd_ok;
      if (rd_ok) m_data = q.pop_front();
      if (wr_ok) q.push_back(wd);
    end
    #1;
    if (chk_en) check_all(tag);
  endtask

  initial begin
    logic [7:0] first;
    int pw;

    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;

    // Hand-derived vectors, starting from an empty FIFO after reset.
    //               f  w  wd     r  cnt fu em af ae ov un vl data
    tbl[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 8'h22, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 8'h33, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[5]  = '{1'b0, 1'b1, 8'h44, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h44};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44};
    tbl[9]  = '{1'b0, 1'b1, 8'h55, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h44};
    tbl[10] = '{1'b1, 1'b1, 8'h66, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44};
    tbl[11] = '{1'b0, 1'b1, 8'h77, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h77};

    // Reset, then an idle cycle must show the reset state.
    model_reset();
    #12 reset_n = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "t1_reset");

    // Vector table.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].f, tbl[i].w, tbl[i].wd, tbl[i].r, 1'b0, "tbl");
      chk($sformatf("vec%0d.count", i),        32'(bus.count),        32'(tbl[i].cnt));
      chk($sformatf("vec%0d.full", i),         32'(bus.full),         32'(tbl[i].full));
      chk($sformatf("vec%0d.empty", i),        32'(bus.empty),        32'(tbl[i].empty));
      chk($sformatf("vec%0d.almost_full", i),  32'(bus.almost_full),  32'(tbl[i].af));
      chk($sformatf("vec%0d.almost_empty", i), 32'(bus.almost_empty), 32'(tbl[i].ae));
      chk($sformatf("vec%0d.overflow", i),     32'(bus.overflow),     32'(tbl[i].ov));
      chk($sformatf("vec%0d.underflow", i),    32'(bus.underflow),    32'(tbl[i].un));
      chk($sformatf("vec%0d.rd_valid", i),     32'(bus.rd_valid),     32'(tbl[i].vld));
      chk($sformatf("vec%0d.rd_data", i),      32'(bus.rd_data),      32'(tbl[i].data));
    end

    // Fill to full, overflow on the 17th write, drain in order.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0, 1'b1, $sformatf("t2_wr%0d", i));
      chk($sformatf("t2_wr%0d.ae_drop", i), 32'(bus.almost_empty), 32'(i + 1 <= 2));
      chk($sformatf("t2_wr%0d.af_rise", i), 32'(bus.almost_full),  32'(i + 1 >= 14));
    end
    step(1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, "t2_wr17");
    chk("t2_ovf_count", 32'(bus.count), 32'd16);
    chk("t2_ovf_flag",  32'(bus.overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, $sformatf("t2_rd%0d", i));
      chk($sformatf("t2_rd%0d.data", i), 32'(bus.rd_data), 32'(i));
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, $sformatf("t2_idle%0d", i));
      chk($sformatf("t2_idle%0d.valid", i), 32'(bus.rd_valid), 32'd0);
    end

    // Pointer wrap: 10 in/out, then 12 in/out.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(8'h20 + i), 1'b0, 1'b1, "t3_wa");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "t3_ra");
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b0, 1'b1, "t3_wb");
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "t3_rb");
      chk($sformatf("t3_rb%0d.data", i), 32'(bus.rd_data), 32'(8'h40 + i));
    end
    chk("t3_end_count", 32'(bus.count), 32'd0);
    chk("t3_end_empty", 32'(bus.empty), 32'd1);

    // Simultaneous read+write while full.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "t4_flush");
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(8'h80 + i), 1'b0, 1'b1, "t4_fill");
    first = 8'h80;
    step(1'b0, 1'b1, 8'h55, 1'b1, 1'b1, "t4_rw_full");
    chk("t4_rw_full.data",  32'(bus.rd_data),  32'(first));
    chk("t4_rw_full.count", 32'(bus.count),    32'd16);
    chk("t4_rw_full.ovf",   32'(bus.overflow), 32'd0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "t4_drain");
    chk("t4_last_is_55", 32'(bus.rd_data), 32'h55);
    step(1'b0, 1'b1, 8'h33, 1'b1, 1'b1, "t4_rw_empty");
    chk("t4_rw_empty.count", 32'(bus.count),     32'd1);
    chk("t4_rw_empty.unf",   32'(bus.underflow), 32'd1);
    chk("t4_rw_empty.valid", 32'(bus.rd_valid),  32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "t4_rd33");
    chk("t4_rd33.data", 32'(bus.rd_data), 32'h33);

    // Flush beats a same-cycle write.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "t5_pre_flush");
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 1'b1, "t5_fill");
    step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1, "t5_ovf");
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "t5_rd");
    chk("t5_pre.count", 32'(bus.count),    32'd5);
    chk("t5_pre.ovf",   32'(bus.overflow), 32'd1);
    step(1'b1, 1'b1, 8'h99, 1'b0, 1'b1, "t5_flush");
    chk("t5_flush.count", 32'(bus.count),    32'd0);
    chk("t5_flush.empty", 32'(bus.empty),    32'd1);
    chk("t5_flush.ovf",   32'(bus.overflow), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, "t5_after");
    chk("t5_after.count", 32'(bus.count), 32'd0);

    // Asynchronous reset between edges with a read in flight.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b1, "t6_wr");
    step(1'b0, 1'b1, 8'hC4, 1'b1, 1'b1, "t6_rd");
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_async");
    chk("t6_async.valid", 32'(bus.rd_valid), 32'd0);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    #2 reset_n = 1'b1;
    step(1'b0, 1'b1, 8'h7E, 1'b0, 1'b1, "t6_wr7e");
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "t6_rd7e");
    chk("t6_rd7e.data",  32'(bus.rd_data),  32'h7E);
    chk("t6_rd7e.valid", 32'(bus.rd_valid), 32'd1);

    // Random traffic, alternating fill-biased and drain-biased phases.
    for (int i = 0; i < 800; i++) begin
      pw = ((i / 100) % 2 == 0) ? 75 : 25;
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 99) < pw),
           8'($urandom),
           ($urandom_range(0, 99) < (100 - pw)),
           1'b1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
